// File: rtl/prio_encoder_hs.sv
// prio_encoder_hs: captures rising edges on request lines into a pending
// vector and presents the highest-numbered unmasked pending line through a
// valid/ready handshake. A presented index is held until it is accepted.
//
// state   | meaning
// --------+---------------------------------------------------------------
// IDLE    | nothing presented; load the encoded index if anything eligible
// PRESENT | out_idx valid and frozen; wait for out_ready
module prio_encoder_hs #(
   parameter int NUM_REQ = 8,
   parameter int IDX_W   = 3
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [NUM_REQ-1:0] req_in,
   input  logic [NUM_REQ-1:0] mask,
   output logic [IDX_W-1:0]   out_idx,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [NUM_REQ-1:0] pending,
   output logic [IDX_W:0]     pend_cnt,
   output logic               overflow,
   input  logic               ovf_clr
);

   typedef enum logic {
      IDLE    = 1'b0,
      PRESENT = 1'b1
   } state_t;

   state_t               state_q, state_d;
   logic [NUM_REQ-1:0]   req_q;
   logic [NUM_REQ-1:0]   mask_q;
   logic [NUM_REQ-1:0]   pend_q, pend_d;
   logic [IDX_W-1:0]     idx_q, idx_d;
   logic                 ovf_q, ovf_d;

   logic [NUM_REQ-1:0]   evt;
   logic [NUM_REQ-1:0]   clr_vec;
   logic [NUM_REQ-1:0]   ovf_vec;
   logic [NUM_REQ-1:0]   eligible;
   logic [IDX_W-1:0]     enc_idx;
   logic                 hs;
   logic [IDX_W:0]       cnt;

   assign evt      = req_in & ~req_q;
   assign hs       = (state_q == PRESENT) && out_ready;
   assign eligible = pend_q & ~mask_q;

   // Pending update: a new event on a bit being granted keeps the bit set
   // (the new event is simply the next request on that line, not a loss).
   always_comb begin
      clr_vec = '0;
      if (hs) begin
         clr_vec[idx_q] = 1'b1;
      end
      ovf_vec = evt & pend_q & ~clr_vec;
      pend_d  = (pend_q & ~clr_vec) | evt;
      ovf_d   = ovf_q;
      if (ovf_clr) begin
         ovf_d = 1'b0;
      end
      if (|ovf_vec) begin
         ovf_d = 1'b1;
      end
   end

   // Highest-numbered eligible line wins; later iterations override earlier.
   always_comb begin
      enc_idx = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (eligible[i]) begin
            enc_idx = IDX_W'(i);
         end
      end
   end

   // Next-state and index load; the index is frozen while presenting.
   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      case (state_q)
         IDLE: begin
            if (|eligible) begin
               state_d = PRESENT;
               idx_d   = enc_idx;
            end
         end
         PRESENT: begin
            if (out_ready) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // State, pending and flag registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         req_q   <= '0;
         mask_q  <= '0;
         pend_q  <= '0;
         idx_q   <= '0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         req_q   <= req_in;
         mask_q  <= mask;
         pend_q  <= pend_d;
         idx_q   <= idx_d;
         ovf_q   <= ovf_d;
      end
   end

   // Population count of the registered pending vector.
   always_comb begin
      cnt = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         cnt = cnt + (IDX_W+1)'(pend_q[i]);
      end
   end

   assign out_valid = (state_q == PRESENT);
   assign out_idx   = idx_q;
   assign pending   = pend_q;
   assign pend_cnt  = cnt;
   assign overflow  = ovf_q;

endmodule

// File: tb/tb_prio_encoder_hs.sv
// Bench for prio_encoder_hs: directed stimulus pushes expected grant indices
// into a queue; a monitor pops and compares on every accepted grant.
module tb_prio_encoder_hs;

   logic       clk;
   logic       rst_n;
   logic [7:0] req_in;
   logic [7:0] mask;
   logic [2:0] out_idx;
   logic       out_valid;
   logic       out_ready;
   logic [7:0] pending;
   logic [3:0] pend_cnt;
   logic       overflow;
   logic       ovf_clr;

   int         checks = 0;
   int         errors = 0;
   int         exp_q[$];

   prio_encoder_hs #(.NUM_REQ(8), .IDX_W(3)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req_in    (req_in),
      .mask      (mask),
      .out_idx   (out_idx),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .pending   (pending),
      .pend_cnt  (pend_cnt),
      .overflow  (overflow),
      .ovf_clr   (ovf_clr)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Monitor: every accepted grant must match the oldest expected index.
   always @(negedge clk) begin
      if (rst_n && out_valid && out_ready) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL grant_unexpected: got out_idx=%0d expected no grant", out_idx);
         end else begin
            chk("grant_idx", 32'(out_idx), 32'(exp_q.pop_front()));
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n = 1'b1; req_in = '0; mask = '0; out_ready = 1'b0; ovf_clr = 1'b0;
      #1 rst_n = 1'b0;
      #1;
      chk("rst_valid",    32'(out_valid), 0);
      chk("rst_idx",      32'(out_idx),   0);
      chk("rst_pending",  32'(pending),   0);
      chk("rst_cnt",      32'(pend_cnt),  0);
      chk("rst_overflow", 32'(overflow),  0);
      tick(); tick();
      rst_n = 1'b1;
      tick();

      // single request, immediate accept
      out_ready = 1'b1; req_in = 8'h01; exp_q.push_back(0);
      tick();
      chk("t1_pend_e1",  32'(pending),   8'h01);
      chk("t1_valid_e1", 32'(out_valid), 0);
      tick();
      chk("t1_valid_e2", 32'(out_valid), 1);
      chk("t1_idx_e2",   32'(out_idx),   0);
      tick();
      chk("t1_pend_e3",  32'(pending),   0);
      chk("t1_valid_e3", 32'(out_valid), 0);
      req_in = '0; tick();

      // two simultaneous events: priority order with idle bubble
      req_in = 8'h44; exp_q.push_back(6); exp_q.push_back(2);
      tick();
      chk("t2_pend",   32'(pending),   8'h44);
      chk("t2_cnt2",   32'(pend_cnt),  2);
      chk("t2_valid0", 32'(out_valid), 0);
      tick();
      chk("t2_valid1", 32'(out_valid), 1);
      chk("t2_idx6",   32'(out_idx),   6);
      tick();
      chk("t2_bubble", 32'(out_valid), 0);
      chk("t2_cnt1",   32'(pend_cnt),  1);
      tick();
      chk("t2_valid2", 32'(out_valid), 1);
      chk("t2_idx2",   32'(out_idx),   2);
      tick();
      chk("t2_valid3", 32'(out_valid), 0);
      chk("t2_cnt0",   32'(pend_cnt),  0);
      req_in = '0; tick();

      // backpressure: no preemption, mask does not disturb the held index
      out_ready = 1'b0; req_in = 8'h08; exp_q.push_back(3);
      tick();
      tick();
      chk("t3_idx3",   32'(out_idx), 3);
      req_in = 8'h88; exp_q.push_back(7);
      tick();
      chk("t3_pend",   32'(pending), 8'h88);
      chk("t3_hold",   32'(out_idx), 3);
      mask = 8'h08;
      tick(); tick();
      chk("t3_hold_masked", 32'(out_idx), 3);
      chk("t3_valid_held",  32'(out_valid), 1);
      mask = '0; out_ready = 1'b1;
      tick();
      chk("t3_after_hs", 32'(pending), 8'h80);
      tick();
      chk("t3_idx7", 32'(out_idx), 7);
      tick();
      chk("t3_drain", 32'(pending), 0);
      req_in = '0; tick();

      // overflow: sticky, clear, clear loses to a new overflow
      out_ready = 1'b0; req_in = 8'h10; exp_q.push_back(4);
      tick();
      chk("t4_pend", 32'(pending), 8'h10);
      req_in = '0; tick();
      chk("t4_no_ovf", 32'(overflow), 0);
      req_in = 8'h10; tick();
      chk("t4_ovf_set", 32'(overflow), 1);
      req_in = '0; tick(); tick();
      chk("t4_sticky", 32'(overflow), 1);
      ovf_clr = 1'b1; tick();
      chk("t4_cleared", 32'(overflow), 0);
      req_in = 8'h10; tick();
      chk("t4_clr_vs_set", 32'(overflow), 1);
      ovf_clr = 1'b0; req_in = '0; out_ready = 1'b1;
      tick();
      chk("t4_drain", 32'(pending), 0);
      ovf_clr = 1'b1; tick(); ovf_clr = 1'b0;
      chk("t4_final_clr", 32'(overflow), 0);
      tick();

      // event on the line being accepted: set wins, re-presented
      out_ready = 1'b0; req_in = 8'h20; exp_q.push_back(5);
      tick();
      req_in = '0; tick();
      chk("t5_idx5", 32'(out_idx), 5);
      out_ready = 1'b1; req_in = 8'h20; exp_q.push_back(5);
      tick();
      chk("t5_pend_kept", 32'(pending),   8'h20);
      chk("t5_no_ovf",    32'(overflow),  0);
      chk("t5_bubble",    32'(out_valid), 0);
      tick();
      chk("t5_again",     32'(out_valid), 1);
      chk("t5_idx5b",     32'(out_idx),   5);
      tick();
      chk("t5_drain",     32'(pending),   0);
      req_in = '0; tick();

      // mask selects the lower line; reset while presenting loses it
      out_ready = 1'b0; mask = 8'h80; req_in = 8'h81;
      tick();
      chk("t6_pend", 32'(pending), 8'h81);
      tick();
      chk("t6_valid", 32'(out_valid), 1);
      chk("t6_idx0",  32'(out_idx),   0);
      rst_n = 1'b0;
      #1;
      chk("t6_rst_valid", 32'(out_valid), 0);
      chk("t6_rst_idx",   32'(out_idx),   0);
      chk("t6_rst_pend",  32'(pending),   0);
      chk("t6_rst_cnt",   32'(pend_cnt),  0);
      req_in = '0; mask = '0; out_ready = 1'b1;
      tick();
      rst_n = 1'b1;
      for (int i = 0; i < 4; i++) begin
         tick();
         chk("t6_no_grant", 32'(out_valid), 0);
      end

      // level high at reset release counts as an event
      rst_n = 1'b0; req_in = 8'h02;
      tick();
      rst_n = 1'b1; exp_q.push_back(1);
      tick();
      chk("t7_pend", 32'(pending), 8'h02);
      tick();
      chk("t7_idx1", 32'(out_idx), 1);
      tick();
      chk("t7_drain", 32'(pending), 0);
      tick(); tick();

      chk("queue_drained", 32'(exp_q.size()), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/prio_encoder_hs.md
PRIO_ENCODER_HS -- requirements
Module: prio_encoder_hs

Interface
REQ-001 SHALL have parameter NUM_REQ, default 8, number of request lines.
REQ-002 SHALL have parameter IDX_W, default 3, encoded index width, equal to clog2(NUM_REQ).
REQ-003 SHALL have port clk  input  1  single clock; all state updates on the rising edge.
REQ-004 SHALL have port rst_n  input  1  reset; asynchronous assert, active-low.
REQ-005 SHALL have port req_in  input  NUM_REQ  request lines; each rising edge is one event.
REQ-006 SHALL have port mask  input  NUM_REQ  1 = line not eligible for encoding; its pending bit is still recorded.
REQ-007 SHALL have port out_idx  output  IDX_W  encoded index of the presented request.
REQ-008 SHALL have port out_valid  output  1  out_idx is valid.
REQ-009 SHALL have port out_ready  input  1  consumer accepts out_idx.
REQ-010 SHALL have port pending  output  NUM_REQ  registered pending vector.
REQ-011 SHALL have port pend_cnt  output  IDX_W+1  number of set pending bits (popcount).
REQ-012 SHALL have port overflow  output  1  sticky flag: event lost on an already-pending line.
REQ-013 SHALL have port ovf_clr  input  1  synchronous clear of overflow.

Function
REQ-014 SHALL register req_in into req_q every cycle; event[i] = req_in[i] & ~req_q[i].
REQ-015 SHALL set pending[i] at the edge where event[i]=1.
REQ-016 SHALL clear pending[out_idx] at the edge where out_valid & out_ready = 1 (handshake).
REQ-017 SHALL give set priority over clear when event and handshake hit the same bit in one cycle: the bit stays 1 and no overflow is raised.
REQ-018 SHALL set overflow when event[i]=1, pending[i]=1 and bit i is not cleared in the same cycle.
REQ-019 SHALL clear overflow on ovf_clr=1; a simultaneous overflow condition wins and overflow stays 1.
REQ-020 SHALL define eligible = pending & ~mask, both taken from registered values.
REQ-021 SHALL encode the highest-numbered eligible bit, so bit NUM_REQ-1 has top priority.
REQ-022 SHALL implement the FSM in two states, IDLE and PRESENT; out_valid=1 only in PRESENT.
REQ-023 SHALL move IDLE->PRESENT when eligible != 0 and load out_idx with the encoded index at that edge.
REQ-024 SHALL stay in IDLE when eligible == 0; out_idx then holds its last value.
REQ-025 SHALL hold out_idx stable in PRESENT until handshake: no preemption by higher-priority arrivals, and mask changes do not alter it.
REQ-026 SHALL move PRESENT->IDLE on handshake; the one-cycle IDLE bubble limits throughput to one grant per 2 cycles.
REQ-027 SHALL give this latency: event sampled at edge k makes pending visible after edge k; out_valid asserts after edge k+1 if the FSM is IDLE.
REQ-028 SHALL keep presenting a masked-after-load index until handshake; clearing then proceeds normally.
REQ-029 SHALL update pend_cnt combinationally from the registered pending vector, ranging 0..NUM_REQ.

Reset
REQ-030 SHALL, on rst_n=0, immediately force state=IDLE, out_valid=0, out_idx=0, pending=0, pend_cnt=0, overflow=0 and req_q=0.
REQ-031 SHALL treat a req_in level already high at reset release as an event at the first clock edge.
REQ-032 SHALL, on reset mid-handshake, lose the presented request with no grant; out_valid drops asynchronously.

Verification
REQ-033 SHALL cover: req_in 8'h00->8'h01 at edge 1, out_ready=1, mask=0 -> pending=8'h01 after edge 1; out_valid=1, out_idx=0 after edge 2; pending=0, out_valid=0 after edge 3.
REQ-034 SHALL cover: events on bits 2 and 6 in the same cycle, out_ready=1 -> grants out_idx=6 then out_idx=2, each out_valid pulse 1 cycle wide and separated by a 1-cycle IDLE; pend_cnt 2->1->0.
REQ-035 SHALL cover: out_ready=0 while out_idx=3 is presented, then an event on bit 7 -> out_idx stays 3 until out_ready=1; next grant is 7.
REQ-036 SHALL cover: second rising edge on bit 4 while pending[4]=1 and no handshake -> overflow=1, sticky; ovf_clr pulse -> overflow=0; simultaneous ovf_clr and new overflow -> overflow=1.
REQ-037 SHALL cover: event on bit 5 in the same cycle as the handshake of out_idx=5 -> pending[5] remains 1, overflow=0, bit 5 presented again after the bubble.
REQ-038 SHALL cover: mask=8'h80 with pending=8'h81 -> out_idx=0; rst_n pulsed low while out_valid=1 -> all outputs 0 immediately, with no grant after release unless a new event occurs.
